// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte interface of the UART receiver.
//   o_Data        8  last good received byte, held until the next good frame
//   o_Valid       1  one-cycle strobe, o_Data is new in this cycle
//   o_FrameError  1  one-cycle strobe, stop bit was sampled low
//   o_Busy        1  high while a frame is in progress
// Modports: master = the receiver (drives), slave = the byte consumer.
interface uart_rx_if;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_FrameError;
  logic       o_Busy;

  modport master (
    output o_Data,
    output o_Valid,
    output o_FrameError,
    output o_Busy
  );

  modport slave (
    input o_Data,
    input o_Valid,
    input o_FrameError,
    input o_Busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Recovers idle-high frames (start bit, 8 data
// bits LSB first, stop bit) from an asynchronous pin, samples each bit at its
// midpoint and presents each byte as a one-cycle strobe on the system clock.
// Ports:
//   i_Clock  system clock, rising edge
//   i_Reset  asynchronous active-high reset
//   i_UART   serial line, asynchronous, idle high
//   rx       uart_rx_if.master: o_Data, o_Valid, o_FrameError, o_Busy
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  input  logic      i_UART,
  uart_rx_if.master rx
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [15:0] HALF_COUNT = 16'(HALF);
  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  logic        sync_1;
  logic        line;
  logic [15:0] bit_count;
  logic [2:0]  bit_index;
  logic [7:0]  shift_reg;
  logic [7:0]  data_reg;
  logic        valid_reg;
  logic        frame_error_reg;

  // Two-flop synchroniser. Resetting both flops high makes the line look idle
  // straight out of reset, so nothing downstream sees a spurious start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_1 <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_1 <= i_UART;
      line   <= sync_1;
    end
  end

  // Receive FSM. Reset lands in S_BREAK so an interrupted frame can only be
  // followed by a start bit after the line has been seen high again; the
  // receiver never locks onto the falling edge of a data bit.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state           <= S_BREAK;
      bit_count       <= '0;
      bit_index       <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      valid_reg       <= 1'b0;
      frame_error_reg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!line) begin
            state     <= S_START;
            bit_count <= '0;
          end
        end

        // A start bit that is high again at its midpoint is a glitch.
        S_START: begin
          if (bit_count == HALF_COUNT) begin
            if (!line) begin
              state     <= S_DATA;
              bit_count <= '0;
              bit_index <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            bit_count <= bit_count + 16'd1;
          end
        end

        // Counting a full bit period from the start-bit midpoint keeps every
        // later sample at the middle of its bit.
        S_DATA: begin
          if (bit_count == LAST_COUNT) begin
            shift_reg[bit_index] <= line;
            bit_count            <= '0;
            if (bit_index == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            bit_count <= bit_count + 16'd1;
          end
        end

        // Leaving at the stop-bit midpoint gives half a bit of slack for a
        // fast sender's next start bit.
        S_STOP: begin
          if (bit_count == LAST_COUNT) begin
            bit_count <= '0;
            if (line) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
              state     <= S_IDLE;
            end else begin
              frame_error_reg <= 1'b1;
              state           <= S_BREAK;
            end
          end else begin
            bit_count <= bit_count + 16'd1;
          end
        end

        S_BREAK: begin
          if (line) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_BREAK;
      endcase
    end
  end

  assign rx.o_Data       = data_reg;
  assign rx.o_Valid      = valid_reg;
  assign rx.o_FrameError = frame_error_reg;
  assign rx.o_Busy       = (state == S_START) || (state == S_DATA) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLKS_PER_BIT=16.
// The whole i_UART / i_Reset waveform is built up front (directed scenarios
// followed by randomised frames with sender bit periods within +-4%), a
// frame-level reference model decodes it from the timing rules, and every
// cycle the DUT outputs are compared against that model.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;
  localparam int MAXC = 12000;

  logic clock = 1'b0;
  logic reset;
  logic uart;

  uart_rx_if rx_bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clock),
    .i_Reset (reset),
    .i_UART  (uart),
    .rx      (rx_bus)
  );

  always #5 clock = ~clock;

  // Stimulus waveform: value driven into cycle e, sampled at rising edge e.
  bit          uartW [MAXC];
  bit          rstW  [MAXC];
  int          len = 0;

  // Reference expectations for the outputs just after rising edge e.
  bit          lineM    [MAXC];
  bit          expValid [MAXC];
  bit          expFerr  [MAXC];
  bit          expBusy  [MAXC];
  logic [7:0]  expByte  [MAXC];
  logic [7:0]  expData  [MAXC];

  logic [7:0]  goodBytes [$];
  logic [7:0]  dutBytes  [$];
  int          dutFerr = 0;
  int          idleActivity = 0;
  int          a5Start = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      passes++;
    end
  endtask

  task automatic pushLevel(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      if (len < MAXC) begin
        uartW[len] = v;
        rstW[len]  = 1'b0;
        len++;
      end
    end
  endtask

  // Frame with a sender period of p100/100 clocks per bit; bit boundaries are
  // rounded down so fractional periods are reproduced on average.
  task automatic pushFrame(input logic [7:0] b, input int p100, input bit stopBit);
    for (int i = 0; i < 10; i++) begin
      bit v;
      int n;
      v = (i == 0) ? 1'b0 : (i == 9) ? stopBit : b[i-1];
      n = ((i + 1) * p100) / 100 - (i * p100) / 100;
      pushLevel(v, n);
    end
  endtask

  task automatic buildStimulus();
    int rs;
    logic [7:0] b;
    // reset for 4 cycles, then 106 idle cycles before the first frame
    pushLevel(1'b1, 4);
    for (int i = 0; i < 4; i++) rstW[i] = 1'b1;
    pushLevel(1'b1, 106);
    // single exact frame
    a5Start = len;
    pushFrame(8'hA5, 1600, 1'b1);
    goodBytes.push_back(8'hA5);
    pushLevel(1'b1, 20);
    // glitch then a good frame
    pushLevel(1'b0, 5);
    pushLevel(1'b1, 30);
    pushFrame(8'h3C, 1600, 1'b1);
    goodBytes.push_back(8'h3C);
    pushLevel(1'b1, 20);
    // framing error with the line held low for 3 more bit periods
    pushFrame(8'h00, 1600, 1'b0);
    pushLevel(1'b0, 3 * CPB);
    pushLevel(1'b1, 20);
    pushFrame(8'h81, 1600, 1'b1);
    goodBytes.push_back(8'h81);
    pushLevel(1'b1, 20);
    // back-to-back frames, fast sender then slow sender
    for (int g = 0; g < 2; g++) begin
      pushFrame(8'h00, (g == 0) ? 1536 : 1664, 1'b1);
      pushFrame(8'hFF, (g == 0) ? 1536 : 1664, 1'b1);
      pushFrame(8'h55, (g == 0) ? 1536 : 1664, 1'b1);
      goodBytes.push_back(8'h00);
      goodBytes.push_back(8'hFF);
      goodBytes.push_back(8'h55);
      pushLevel(1'b1, 20);
    end
    // reset asserted during (low) data bit 3 of 0xF0, released in bit 4
    rs = len;
    pushFrame(8'hF0, 1600, 1'b1);
    for (int i = rs + 72; i < rs + 90; i++) rstW[i] = 1'b1;
    pushLevel(1'b1, 30);
    pushFrame(8'h5A, 1600, 1'b1);
    goodBytes.push_back(8'h5A);
    pushLevel(1'b1, 20);
    // randomised frames, gaps (sometimes none) and glitches
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        pushLevel(1'b0, $urandom_range(1, 6));
        pushLevel(1'b1, $urandom_range(12, 30));
      end
      b = 8'($urandom_range(0, 255));
      pushFrame(b, $urandom_range(1536, 1664), 1'b1);
      goodBytes.push_back(b);
      if ($urandom_range(0, 3) != 0) pushLevel(1'b1, $urandom_range(2, 25));
    end
    pushLevel(1'b1, 40);
  endtask

  // Frame-level decode of the waveform: start detected two edges after the
  // pin falls, midpoint check HALF+1 edges later, then one sample per bit
  // period, result at the stop-bit sample.
  task automatic buildModel();
    bit f1, f2, needHigh;
    int e, s, mid, stopE, endE, r;
    logic [7:0] b, cur;
    f1 = 1'b1;
    f2 = 1'b1;
    for (int k = 0; k < len; k++) begin
      lineM[k] = f2;
      if (rstW[k]) begin
        f1 = 1'b1;
        f2 = 1'b1;
      end else begin
        f2 = f1;
        f1 = uartW[k];
      end
      expValid[k] = 1'b0;
      expFerr[k]  = 1'b0;
      expBusy[k]  = 1'b0;
      expByte[k]  = 8'h00;
    end
    e = 0;
    needHigh = 1'b1;
    while (e < len) begin
      if (rstW[e]) begin
        needHigh = 1'b1;
        e++;
      end else if (needHigh) begin
        if (lineM[e]) needHigh = 1'b0;
        e++;
      end else if (lineM[e]) begin
        e++;
      end else begin
        s = e;
        mid = s + 1 + HALF;
        stopE = mid + 9 * CPB;
        endE = (mid < len && lineM[mid]) ? mid : stopE;
        r = -1;
        for (int k = s + 1; k <= endE && k < len; k++) begin
          if (rstW[k] && r < 0) r = k;
        end
        if (r >= 0) begin
          for (int k = s; k < r; k++) expBusy[k] = 1'b1;
          e = r;
        end else if (endE >= len) begin
          for (int k = s; k < len; k++) expBusy[k] = 1'b1;
          e = len;
        end else if (endE == mid) begin
          for (int k = s; k < mid; k++) expBusy[k] = 1'b1;
          e = mid + 1;
        end else begin
          for (int k = s; k < stopE; k++) expBusy[k] = 1'b1;
          for (int k = 0; k < 8; k++) b[k] = lineM[mid + (k + 1) * CPB];
          if (lineM[stopE]) begin
            expValid[stopE] = 1'b1;
            expByte[stopE]  = b;
          end else begin
            expFerr[stopE] = 1'b1;
            needHigh = 1'b1;
          end
          e = stopE + 1;
        end
      end
    end
    cur = 8'h00;
    for (int k = 0; k < len; k++) begin
      if (rstW[k]) cur = 8'h00;
      else if (expValid[k]) cur = expByte[k];
      expData[k] = cur;
    end
  endtask

  task automatic applyStimulus(input int e);
    uart  = uartW[e];
    reset = rstW[e];
  endtask

  initial begin
    logic [10:0] act;
    logic [10:0] exp;
    buildStimulus();
    buildModel();
    // pin the model against hand-derived timing: strobe at edge 154
    checkOutput("model_a5_strobe", 32'(expValid[a5Start + 154]), 32'd1);
    checkOutput("model_a5_early", 32'(expValid[a5Start + 153]), 32'd0);
    checkOutput("model_a5_byte", 32'(expByte[a5Start + 154]), 32'hA5);
    applyStimulus(0);
    for (int e = 0; e < len; e++) begin
      @(negedge clock);
      act = {rx_bus.o_Valid, rx_bus.o_FrameError, rx_bus.o_Busy, rx_bus.o_Data};
      exp = {expValid[e], expFerr[e], expBusy[e], expData[e]};
      checkOutput($sformatf("cycle_%0d", e), 32'(act), 32'(exp));
      if (e == 2) checkOutput("reset_state", 32'(act), 32'd0);
      if (e >= 4 && e < a5Start && (rx_bus.o_Valid || rx_bus.o_FrameError || rx_bus.o_Busy))
        idleActivity++;
      if (e == a5Start + 153) checkOutput("a5_not_early", 32'(rx_bus.o_Valid), 32'd0);
      if (e == a5Start + 154) begin
        checkOutput("a5_strobe", 32'(rx_bus.o_Valid), 32'd1);
        checkOutput("a5_data", 32'(rx_bus.o_Data), 32'hA5);
      end
      if (rx_bus.o_Valid) dutBytes.push_back(rx_bus.o_Data);
      if (rx_bus.o_FrameError) dutFerr++;
      if (e + 1 < len) applyStimulus(e + 1);
    end
    checkOutput("idle_after_reset", 32'(idleActivity), 32'd0);
    checkOutput("frame_error_count", 32'(dutFerr), 32'd1);
    checkOutput("byte_count", 32'(dutBytes.size()), 32'(goodBytes.size()));
    for (int i = 0; i < goodBytes.size() && i < dutBytes.size(); i++) begin
      checkOutput($sformatf("byte_%0d", i), 32'(dutBytes[i]), 32'(goodBytes[i]));
    end
    checkOutput("busy_at_end", 32'(rx_bus.o_Busy), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
